// File: rtl/seven_seg_to_bcd_capture.sv
// Decodes a multiplexed 7-segment drive bus back into BCD, one word per complete scan.
// A digit is accepted only after its pattern has been stable for STABLE_CYCLES registered samples.
module seven_seg_to_bcd_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = NUM_DIGITS + 7;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [IW-1:0]                in_q;
    logic [IW-1:0]                prev_q;
    logic [CW-1:0]                cnt;
    logic [CW-1:0]                cnt_next;
    logic [NUM_DIGITS-1:0]        en_q;
    logic [6:0]                   seg_q;
    logic                         changed;
    logic                         capture;
    logic                         onehot;
    logic                         accept;
    logic                         frame_done;
    logic [NUM_DIGITS-1:0]        seen;
    logic [NUM_DIGITS-1:0]        seen_next;
    logic [NUM_DIGITS-1:0][3:0]   shadow;
    logic [NUM_DIGITS-1:0]        err_mask;
    logic [3:0]                   dec_val;
    logic                         dec_ok;

    assign en_q       = in_q[IW-1:7];
    assign seg_q      = in_q[6:0];
    assign changed    = (in_q != prev_q);
    assign onehot     = (en_q != '0) && ((en_q & (en_q - NUM_DIGITS'(1))) == '0);
    assign frame_done = &seen;

    // Stability counter: restarts at 1 on any change, saturates at STABLE_CYCLES.
    always_comb begin
        cnt_next = cnt;
        if (changed)
            cnt_next = CW'(1);
        else if (cnt != CNT_MAX)
            cnt_next = cnt + CW'(1);
    end

    // Strobe only on arrival at the limit; "changed" lets STABLE_CYCLES=1 capture every change.
    assign capture = (cnt_next == CNT_MAX) && (changed || (cnt != CNT_MAX));
    assign accept  = capture && onehot;

    always_comb begin
        dec_val = 4'hF;
        dec_ok  = 1'b1;
        case (seg_q)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // A capture landing on the frame-completion cycle belongs to the next frame.
    always_comb begin
        seen_next = frame_done ? '0 : seen;
        if (accept)
            seen_next = seen_next | en_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= '0;
            prev_q <= '0;
            cnt    <= '0;
        end else begin
            in_q   <= {dig_en, seg_in};
            prev_q <= in_q;
            cnt    <= cnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen     <= '0;
            shadow   <= '0;
            err_mask <= '0;
        end else begin
            seen <= seen_next;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (accept && en_q[i]) begin
                    shadow[i]   <= dec_val;
                    err_mask[i] <= ~dec_ok;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_out     <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                bcd_out   <= shadow;
                digit_err <= err_mask;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_to_bcd_capture.sv
// Directed bench for seven_seg_to_bcd_capture: table of full scans plus hand-written
// sequences for glitches, multi-hot enables, overwrites and mid-frame reset.
module tb_seven_seg_to_bcd_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = '0;
    logic [3:0]  dig_en = '0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    int total = 0;
    int bad = 0;
    int fv_count = 0;

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101,
                           S3 = 7'b1111001, S4 = 7'b0110011, S5 = 7'b1011011,
                           S6 = 7'b1011111, S7 = 7'b1110000, S8 = 7'b1111111,
                           S9 = 7'b1111011;

    typedef struct {
        logic [3:0][6:0] segs;
        logic [15:0]     exp_bcd;
        logic [3:0]      exp_err;
    } frame_vec_t;

    frame_vec_t vecs [4];

    seven_seg_to_bcd_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .seg_in(seg_in),
        .dig_en(dig_en),
        .bcd_out(bcd_out),
        .digit_err(digit_err),
        .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_valid) fv_count++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] en, input logic [6:0] seg, input int cycles);
        dig_en = en;
        seg_in = seg;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scanFrame(input logic [3:0][6:0] segs);
        for (int d = 0; d < 4; d++) applyStimulus(4'(1 << d), segs[d], 6);
    endtask

    task automatic waitFrame(input string name);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (frame_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({name, "_pulse_seen"}, 32'(got), 32'd1);
    endtask

    task automatic checkFrame(input string name, input logic [15:0] eb, input logic [3:0] ee, input int c0);
        checkOutput({name, "_bcd"}, 32'(bcd_out), 32'(eb));
        checkOutput({name, "_err"}, 32'(digit_err), 32'(ee));
        repeat (8) @(posedge clk);
        #1;
        checkOutput({name, "_pulses"}, 32'(fv_count - c0), 32'd1);
        checkOutput({name, "_hold_bcd"}, 32'(bcd_out), 32'(eb));
    endtask

    initial begin
        int c0;

        vecs[0] = '{segs: {S4, S3, S2, S1}, exp_bcd: 16'h4321, exp_err: 4'b0000};
        vecs[1] = '{segs: {S7, 7'b1000000, S8, S9}, exp_bcd: 16'h7F89, exp_err: 4'b0100};
        vecs[2] = '{segs: {7'b0000000, S6, S5, S0}, exp_bcd: 16'hF650, exp_err: 4'b1000};
        vecs[3] = '{segs: {S6, S7, 7'b0110001, 7'b1111100}, exp_bcd: 16'h67FF, exp_err: 4'b0011};

        repeat (3) @(negedge clk);
        checkOutput("reset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("reset_err", 32'(digit_err), 32'h0);
        checkOutput("reset_fv", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("idle_no_frame", 32'(fv_count), 32'd0);

        for (int v = 0; v < 4; v++) begin
            c0 = fv_count;
            scanFrame(vecs[v].segs);
            waitFrame($sformatf("vec%0d", v));
            checkFrame($sformatf("vec%0d", v), vecs[v].exp_bcd, vecs[v].exp_err, c0);
        end

        // Glitch: 8 for 3 cycles must not be captured before the real 0.
        c0 = fv_count;
        applyStimulus(4'b0001, S8, 3);
        applyStimulus(4'b0001, S0, 6);
        applyStimulus(4'b0010, S1, 6);
        applyStimulus(4'b0100, S2, 6);
        applyStimulus(4'b1000, S3, 6);
        waitFrame("glitch");
        checkFrame("glitch", 16'h3210, 4'b0000, c0);

        // Multi-hot enable held mid-scan is ignored.
        c0 = fv_count;
        applyStimulus(4'b0001, S5, 6);
        applyStimulus(4'b0010, S6, 6);
        applyStimulus(4'b0011, S1, 10);
        applyStimulus(4'b0100, S7, 6);
        checkOutput("multihot_partial", 32'(fv_count - c0), 32'd0);
        applyStimulus(4'b1000, S8, 6);
        waitFrame("multihot");
        checkFrame("multihot", 16'h8765, 4'b0000, c0);

        // Overwrite of digit 1 within one frame.
        c0 = fv_count;
        applyStimulus(4'b0001, S0, 6);
        applyStimulus(4'b0010, S5, 6);
        applyStimulus(4'b0010, S6, 6);
        applyStimulus(4'b0100, S1, 6);
        applyStimulus(4'b1000, S2, 6);
        waitFrame("overwrite");
        checkFrame("overwrite", 16'h2160, 4'b0000, c0);

        // Mid-frame reset clears outputs asynchronously.
        c0 = fv_count;
        scanFrame(vecs[0].segs);
        waitFrame("prereset");
        checkFrame("prereset", 16'h4321, 4'b0000, c0);
        applyStimulus(4'b0001, S1, 6);
        applyStimulus(4'b0010, S2, 6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset_bcd", 32'(bcd_out), 32'h0);
        checkOutput("midreset_err", 32'(digit_err), 32'h0);
        checkOutput("midreset_fv", 32'(frame_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c0 = fv_count;
        scanFrame({S9, S9, S9, S9});
        waitFrame("after_reset");
        checkFrame("after_reset", 16'h9999, 4'b0000, c0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seven_seg_to_bcd_capture.md
Name: seven_seg_to_bcd_capture

Overview:
- Reverse path of the team's BCD-to-7-segment encoder: samples a multiplexed NUM_DIGITS-digit 7-segment drive bus (segment lines plus one-hot digit enables) and decodes it back to BCD.
- Each digit pattern must be stable for a set number of cycles before it is accepted. One BCD word is emitted per complete display scan.
- Used as an in-system checker and loopback monitor on display outputs.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 4, consecutive identical registered samples needed before a digit is captured (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- seg_in  input  7  segment lines, active-high; seg_in[6]=a, seg_in[5]=b, seg_in[4]=c, seg_in[3]=d, seg_in[2]=e, seg_in[1]=f, seg_in[0]=g.
- dig_en  input  NUM_DIGITS  digit enables, active-high, expected one-hot; bit i selects digit i.
- bcd_out  output  4*NUM_DIGITS  captured frame; digit i is at bcd_out[4i+3:4i].
- digit_err  output  NUM_DIGITS  per-digit flag: an invalid pattern was captured for that digit in the last frame.
- frame_valid  output  1  one-cycle pulse when bcd_out and digit_err update.

Behaviour:
- Reset (asynchronous, active-high): bcd_out=0, digit_err=0, frame_valid=0. All internal registers clear: input register, stability counter, shadow digits, seen mask, error mask.
- Input stage: {dig_en, seg_in} is registered every cycle into in_q. No other logic reads the raw inputs.
- Stability counter cnt:
  - Width is clog2(STABLE_CYCLES+1).
  - If in_q differs from its previous-cycle value, cnt is set to 1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - After reset the previous value is all-zero, so an all-zero bus already counts as stable.
- Capture strobe: asserted for exactly one cycle, on the cycle cnt becomes equal to STABLE_CYCLES. A pattern held longer does not re-capture. With STABLE_CYCLES=1, every change captures.
- On capture, with dig_en in in_q exactly one-hot at bit i:
  - Decode seg: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
  - Valid pattern: shadow[i] <= decoded value, err_mask[i] <= 0.
  - Any other pattern, including blank 0000000: shadow[i] <= 4'hF, err_mask[i] <= 1.
  - In both cases seen[i] <= 1.
  - Capturing a digit that is already seen in the current frame overwrites its shadow and error bit.
- On capture with dig_en zero or multi-hot: the capture is discarded; no state change.
- Frame completion:
  - The cycle after seen becomes all-ones: bcd_out <= shadow, digit_err <= err_mask, frame_valid=1 for one cycle, seen <= 0.
  - A capture arriving in that same cycle is applied after the clear and counts toward the next frame.
- Latency: the input becomes stable at edge E. Capture takes effect at edge E+STABLE_CYCLES. If that capture completes the frame, frame_valid is high in the cycle after edge E+STABLE_CYCLES+1.
- Outputs hold between frames. Partial frames never update outputs.
- Reset mid-frame: discards the partial frame and clears the outputs immediately.

Test Plan:
- Reset, then scan digits 0..3 with patterns for 1,2,3,4 (seg=0110000,1101101,1111001,0110011), each held 6 cycles -> single frame_valid pulse, bcd_out=16'h4321, digit_err=0000.
- Glitch rejection, STABLE_CYCLES=4: digit 0 shows 1111111 for 3 cycles, then 1111110 for 6 cycles -> digit 0 captured as 0, not 8; the 1111111 glitch is never captured.
- Invalid pattern 1000000 on digit 2 within an otherwise valid frame 9,8,?,7 -> bcd_out=16'h7F89, digit_err=0100.
- dig_en=0011 held 10 cycles mid-scan, then remaining digits -> multi-hot sample ignored; frame completes only after all four one-hot digits, and no extra frame_valid pulse.
- Digit 1 driven with 5 and then 6 before the frame completes -> bcd_out digit 1 = 6 (overwrite).
- Assert rst after 2 of 4 digits of a frame with bcd_out=16'h4321 -> outputs 0 within the same cycle. After release, a full scan of 9,9,9,9 -> frame_valid once, bcd_out=16'h9999.
